// File: rtl/div_pkg.sv
// Shared types, sizes and sign helpers for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
    return (~x) + DIV_WIDTH'(1);
  endfunction

  // Magnitude of x when treated as signed; 0x80000000 maps to itself.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x,
                                                   input logic              is_signed);
    return (is_signed && x[DIV_WIDTH-1]) ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Controller-to-divider bundle: start command, operands, results and status.
interface div_unit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
);
  // Handshake: load is a one-cycle start pulse, honoured only while the unit
  // is IDLE (busy low); any load while busy, including the done cycle, is
  // dropped. done pulses for exactly one cycle when hi/lo hold the result.
  logic             load;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [CNT_W-1:0] counter;
  div_state_t       state;

  modport master (
    output load, is_signed, dividend, divisor,
    input  hi, lo, busy, done, div_zero, counter, state
  );

  modport slave (
    input  load, is_signed, dividend, divisor,
    output hi, lo, busy, done, div_zero, counter, state
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, subtract D if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic           fits;

  // R < D always holds, so the shifted remainder fits in WIDTH+1 bits.
  assign r_shift = {r, q[WIDTH-1]};
  assign fits    = (r_shift >= {1'b0, d});
  assign r_next  = fits ? WIDTH'(r_shift - {1'b0, d}) : r_shift[WIDTH-1:0];
  assign q_next  = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS div/divu: quotient to lo, remainder to hi.
// Optional DIV_ZERO_EXC_EN: divide-by-zero skips iterations and raises div_zero.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] counter_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_nxt, q_nxt;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] hi_q, lo_q;
`ifdef DIV_ZERO_EXC_EN
  logic             zero_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.load) state_d = CALC;
`ifdef DIV_ZERO_EXC_EN
      CALC: if (zero_q || counter_q == CNT_W'(1)) state_d = FIX;
`else
      CALC: if (counter_q == CNT_W'(1)) state_d = FIX;
`endif
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef DIV_ZERO_EXC_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            q_q       <= abs_val(bus.dividend, bus.is_signed);
            d_q       <= abs_val(bus.divisor, bus.is_signed);
            r_q       <= '0;
            q_neg     <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg     <= bus.is_signed & bus.dividend[WIDTH-1];
            counter_q <= CNT_W'(DIV_ITERS);
`ifdef DIV_ZERO_EXC_EN
            zero_q    <= (bus.divisor == '0);
`endif
          end
        end
        CALC: begin
`ifdef DIV_ZERO_EXC_EN
          // A zero divisor abandons the iterations and leaves hi/lo untouched.
          if (zero_q) begin
            counter_q <= '0;
          end else begin
            r_q       <= r_nxt;
            q_q       <= q_nxt;
            counter_q <= counter_q - CNT_W'(1);
          end
`else
          r_q       <= r_nxt;
          q_q       <= q_nxt;
          counter_q <= counter_q - CNT_W'(1);
`endif
        end
        FIX: begin
`ifdef DIV_ZERO_EXC_EN
          if (!zero_q) begin
            lo_q <= q_neg ? negate(q_q) : q_q;
            hi_q <= r_neg ? negate(r_q) : r_q;
          end
`else
          lo_q <= q_neg ? negate(q_q) : q_q;
          hi_q <= r_neg ? negate(r_q) : r_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.counter = counter_q;
  assign bus.state   = state_q;
`ifdef DIV_ZERO_EXC_EN
  assign bus.div_zero = (state_q == DONE) & zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors,
// latency, busy width, ignored loads and mid-operation reset.
module tb_div_unit;
  import div_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic exp_dz,
                        input int exp_lat, input int inject_at, input bit load_in_done);
    int edges;
    int busy_cyc;
    @(negedge clk);
    bus.load = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.load = 1'b0;
    edges = 1;
    busy_cyc = 0;
    check({tag, "_cnt_start"}, 32'(bus.counter), 32'd32);
    while (edges < 100) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) break;
      if (edges == 5) begin
        check({tag, "_lo_hold"}, bus.lo, prev_lo);
        check({tag, "_hi_hold"}, bus.hi, prev_hi);
      end
      if (inject_at != 0 && edges == inject_at) begin
        bus.load = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
      end
      @(negedge clk);
      bus.load = 1'b0;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
    if (load_in_done) begin
      bus.load = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
    end
    @(negedge clk);
    bus.load = 1'b0;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_after"}, 32'(bus.state), 32'(IDLE));
    if (load_in_done) begin
      repeat (3) @(negedge clk);
      check({tag, "_busy_after_ignored"}, 32'(bus.busy), 32'd0);
      check({tag, "_lo_after_ignored"}, bus.lo, exp_lo);
    end
    prev_lo = exp_lo;
    prev_hi = exp_hi;
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    bus.load = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_counter", 32'(bus.counter), 32'd0);
    check("reset_state", 32'(bus.state), 32'(IDLE));

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 0, 1'b0);
    run_op("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 1'b0, 34, 0, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 0, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 0, 1'b0);
    run_op("divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 34, 0, 1'b1);
`ifdef DIV_ZERO_EXC_EN
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, prev_lo, prev_hi, 1'b1, 3, 0, 1'b0);
`else
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 34, 0, 1'b0);
`endif
    run_op("load_while_busy", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 34, 10, 1'b0);

    // Abort an operation with reset partway through the iterations.
    @(negedge clk);
    bus.load = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd7;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_counter", 32'(bus.counter), 32'd0);
    check("rst_mid_state", 32'(bus.state), 32'(IDLE));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    prev_lo = '0;
    prev_hi = '0;
    run_op("after_rst", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 34, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
